dmem_arbiter: RTL and testbench

- Shares the single-port data RAM between the CPU data port and one secondary requester (loader/debug DMA) using a req/ack handshake.
- The RAM has asynchronous read and synchronous write. The CPU has no stall input, so it always has priority. The DMA is serviced only in cycles where the CPU makes no data access.
- Sits between the CPU data_addr/data_out/data_in/data_we pins and the RAM. The CPU additionally provides a read strobe, asserted when executing lw.

---
 rtl/dmem_arbiter_if.sv | 15 +
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - secondary (loader/debug DMA) req/ack channel into the data RAM arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data RAM arbiter; DMEM_ARB_STALL_EN adds a forced DMA grant on starvation
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  dmem_arbiter_if.slave     dma,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state, state_n;
  logic              grant;
  logic              cpu_access;
  logic              starve_hit;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] rdata_q;

  // A stalled CPU holds its instruction, so its strobes must not reach the RAM.
  assign cpu_access = (cpu_re | cpu_we) & ~cpu_stall;
  assign starve_hit = (state == IDLE) && dma.req && !grant &&
                      (wait_cnt == 8'(STARVE_LIMIT));

  assign cpu_rdata = mem_rdata;
  assign dma.ack   = (state == ACK);
  assign dma.rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      rdata_q   <= '0;
      cpu_stall <= 1'b0;
    end else begin
      state     <= state_n;
      cpu_stall <= STALL_EN && starve_hit;
      if (grant && !dma.we)
        rdata_q <= mem_rdata;
      if (grant || !dma.req)
        wait_cnt <= 8'd0;
      else if (state == IDLE && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (dma.req && !cpu_access) begin
          grant   = 1'b1;
          state_n = ACK;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (grant) begin
      mem_addr  = dma.addr;
      mem_wdata = dma.wdata;
      mem_we    = dma.we;
    end else if (cpu_access) begin
      mem_we = cpu_we;
    end
    if (!reset)
      mem_we = 1'b0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed checks of dmem_arbiter against a behavioural async-read RAM
module tb_dmem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [0:255];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acks;
  int n_writes;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dma ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma       (dma.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    reset = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 32'h0; cpu_we = 1'b1; cpu_re = 1'b0;
    dma.req = 1'b1; dma.we = 1'b1; dma.addr = 16'h0008; dma.wdata = 32'h5555_5555;
    #1;
    check("rst_mem_we_pre", mem_we, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_ack", dma.ack, 1'b0);
      check("rst_rdata", dma.rdata, 32'h0);
      check("rst_stall", cpu_stall, 1'b0);
    end
    check("rst_ram_untouched", ram[0], 32'h0);

    // DMA write then read-back with the CPU idle
    reset = 1'b1; cpu_we = 1'b0;
    dma.req = 1'b1; dma.we = 1'b1; dma.addr = 16'h0010; dma.wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_grant_we", mem_we, 1'b1);
    check("wr_grant_addr", mem_addr, 32'h0010);
    check("wr_grant_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_grant_noack", dma.ack, 1'b0);
    tick();
    check("wr_ack", dma.ack, 1'b1);
    check("wr_ram", ram[16], 32'hDEAD_BEEF);
    check("wr_ack_no_access", mem_we, 1'b0);
    dma.req = 1'b0;
    tick();
    check("wr_ack_drop", dma.ack, 1'b0);
    dma.req = 1'b1; dma.we = 1'b0;
    #1;
    check("rd_grant_we", mem_we, 1'b0);
    tick();
    check("rd_ack", dma.ack, 1'b1);
    check("rd_data", dma.rdata, 32'hDEAD_BEEF);
    dma.req = 1'b0;
    tick();
    check("rd_data_held", dma.rdata, 32'hDEAD_BEEF);

    // CPU load blocks the DMA for 5 cycles
    ram[32] = 32'h1234_5678; ram[48] = 32'hCAFE_F00D;
    cpu_re = 1'b1; cpu_addr = 16'h0030;
    dma.req = 1'b1; dma.we = 1'b0; dma.addr = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("blk_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
      check("blk_mem_addr", mem_addr, 32'h0030);
      tick();
      check("blk_noack", dma.ack, 1'b0);
    end
    check("blk_wait_cnt", dut.wait_cnt, 8'd5);
    cpu_re = 1'b0;
    #1;
    check("blk_grant_addr", mem_addr, 32'h0020);
    tick();
    check("blk_ack", dma.ack, 1'b1);
    check("blk_rdata", dma.rdata, 32'h1234_5678);
    check("blk_wait_clr", dut.wait_cnt, 8'd0);
    dma.req = 1'b0;
    tick();

    // Continuous request: one access per two cycles
    dma.req = 1'b1; dma.we = 1'b1; dma.addr = 16'h0040; dma.wdata = 32'hA5A5_0001;
    n_acks = 0; n_writes = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (mem_we) n_writes++;
      tick();
      if (dma.ack) n_acks++;
      check("thru_ack_pattern", dma.ack, (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    check("thru_acks", n_acks, 4);
    check("thru_writes", n_writes, 4);
    dma.req = 1'b0;
    tick();

    // Same-cycle CPU store and DMA write to one address
    cpu_we = 1'b1; cpu_addr = 16'h0004; cpu_wdata = 32'h1;
    dma.req = 1'b1; dma.we = 1'b1; dma.addr = 16'h0004; dma.wdata = 32'h2;
    tick();
    check("coll_cpu_first", ram[4], 32'h1);
    check("coll_noack", dma.ack, 1'b0);
    cpu_we = 1'b0;
    tick();
    check("coll_dma_second", ram[4], 32'h2);
    check("coll_ack", dma.ack, 1'b1);
    dma.req = 1'b0;
    tick();

    // Withdrawn request clears the counter without an access
    cpu_re = 1'b1; cpu_addr = 16'h0030;
    dma.req = 1'b1; dma.we = 1'b1; dma.addr = 16'h0050; dma.wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) tick();
    check("wd_wait_cnt", dut.wait_cnt, 8'd3);
    dma.req = 1'b0; cpu_re = 1'b0;
    #1;
    check("wd_no_access", mem_we, 1'b0);
    tick();
    check("wd_wait_clr", dut.wait_cnt, 8'd0);
    check("wd_noack", dma.ack, 1'b0);
    check("wd_ram", ram[80], 32'h0);

    // Reset during ACK drops the ack
    dma.req = 1'b1; dma.we = 1'b0; dma.addr = 16'h0010;
    tick();
    check("rack_ack", dma.ack, 1'b1);
    reset = 1'b0; dma.req = 1'b0;
    tick();
    check("rack_ack_drop", dma.ack, 1'b0);
    check("rack_rdata_clr", dma.rdata, 32'h0);
    reset = 1'b1;
    tick();

    // Starvation: CPU loads every cycle with a pending DMA read
    cpu_re = 1'b1; cpu_addr = 16'h0030;
    dma.req = 1'b1; dma.we = 1'b0; dma.addr = 16'h0020;
`ifdef DMEM_ARB_STALL_EN
    for (int i = 0; i < 5; i++) begin
      check("stv_stall_low", cpu_stall, 1'b0);
      tick();
    end
    check("stv_stall_pulse", cpu_stall, 1'b1);
    check("stv_forced_addr", mem_addr, 32'h0020);
    tick();
    check("stv_ack", dma.ack, 1'b1);
    check("stv_rdata", dma.rdata, 32'h1234_5678);
    check("stv_stall_end", cpu_stall, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stv_stall_off", cpu_stall, 1'b0);
      check("stv_noack", dma.ack, 1'b0);
    end
    check("stv_wait_cnt", dut.wait_cnt, 8'd20);
    cpu_re = 1'b0;
    tick();
    check("stv_late_ack", dma.ack, 1'b1);
`endif
    dma.req = 1'b0; cpu_re = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
